// File: rtl/crc_frame_append.sv
// crc_frame_append: transmit framer that forwards a sof/eof-delimited byte
// stream through a single output register and appends the frame check
// sequence right after the last payload byte.
// Optional feature macro: CRC_APPEND_PAD_EN (zero-pads short frames up to
// C_MIN_LEN bytes; the pad is covered by the FCS).
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | between frames; sof byte starts a frame, other bytes dropped
// S_DATA | forwarding payload bytes, CRC updated per byte
// S_PAD  | input stalled, emitting 8'h00 until minimum length reached
// S_FCS  | input stalled, emitting the C_GEN_WIDTH/8 FCS bytes
module crc_frame_append #(
    parameter int unsigned               C_GEN_WIDTH = 32,
    parameter logic [C_GEN_WIDTH-1:0]    C_GEN_SEQ   = 32'h04c11db7,
    parameter logic [C_GEN_WIDTH-1:0]    C_INIT      = 32'hffff_ffff,
    parameter bit                        C_OUT_INV   = 1'b1,
    parameter int unsigned               C_MIN_LEN   = 60
) (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic [7:0] I_data,
    input  logic       I_data_v,
    input  logic       I_sof,
    input  logic       I_eof,
    output logic       O_ready,
    output logic [7:0] O_data,
    output logic       O_data_v,
    output logic       O_sof,
    output logic       O_eof,
    input  logic       I_ready,
    output logic       O_drop
);

    localparam int unsigned NB       = C_GEN_WIDTH / 8;
    localparam logic [2:0]  FCS_LAST = 3'(NB - 1);

    if ((C_GEN_WIDTH % 8) != 0 || C_GEN_WIDTH == 0 || C_GEN_WIDTH > 32) begin : g_bad_width
        $error("crc_frame_append: C_GEN_WIDTH must be 8, 16 or 32");
    end
    if (C_MIN_LEN == 0 || C_MIN_LEN > 65535) begin : g_bad_min_len
        $error("crc_frame_append: C_MIN_LEN must be in 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAD  = 2'd2,
        S_FCS  = 2'd3
    } state_t;

    // Serial CRC over one byte, d[0] shifted in first.
    function automatic logic [C_GEN_WIDTH-1:0] crc_byte(input logic [C_GEN_WIDTH-1:0] r_in,
                                                        input logic [7:0]             d);
        logic [C_GEN_WIDTH-1:0] r;
        r = r_in;
        for (int i = 0; i < 8; i++) begin
            r = {r[C_GEN_WIDTH-2:0], 1'b0} ^ ({C_GEN_WIDTH{r[C_GEN_WIDTH-1] ^ d[i]}} & C_GEN_SEQ);
        end
        return r;
    endfunction

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] o;
        for (int i = 0; i < 8; i++) o[i] = b[7-i];
        return o;
    endfunction

    state_t                 state, state_nxt;
    logic [C_GEN_WIDTH-1:0] crc, crc_nxt;
    logic [2:0]             fcs_left, fcs_nxt;
    logic                   rdy_en;
    logic [7:0]             out_data, ld_data, fcs_top;
    logic                   out_v, out_sof, out_eof;
    logic                   ld, ld_sof, ld_eof;
    logic                   drop, drop_nxt;
    logic                   out_free, ready_int, in_xfer, go_pad;
`ifdef CRC_APPEND_PAD_EN
    // Bytes still missing to reach C_MIN_LEN; saturates at zero.
    logic [15:0]            pad_left, pad_nxt;
`endif

    assign out_free  = !out_v || I_ready;
    assign ready_int = rdy_en && out_free && (state == S_IDLE || state == S_DATA);
    assign in_xfer   = I_data_v && ready_int;
    assign fcs_top   = C_OUT_INV ? ~crc[C_GEN_WIDTH-1 -: 8] : crc[C_GEN_WIDTH-1 -: 8];

    // Next-state, CRC/counter updates and output-register load decision.
    always_comb begin
        state_nxt = state;
        crc_nxt   = crc;
        fcs_nxt   = fcs_left;
        ld        = 1'b0;
        ld_data   = out_data;
        ld_sof    = 1'b0;
        ld_eof    = 1'b0;
        drop_nxt  = 1'b0;
        go_pad    = 1'b0;
`ifdef CRC_APPEND_PAD_EN
        pad_nxt   = pad_left;
`endif
        case (state)
            S_IDLE: begin
                if (in_xfer) begin
                    if (I_sof) begin
                        crc_nxt = crc_byte(C_INIT, I_data);
                        ld      = 1'b1;
                        ld_data = I_data;
                        ld_sof  = 1'b1;
`ifdef CRC_APPEND_PAD_EN
                        pad_nxt = 16'(C_MIN_LEN - 1);
                        go_pad  = (pad_nxt != 16'd0);
`endif
                        if (I_eof) begin
                            state_nxt = go_pad ? S_PAD : S_FCS;
                            fcs_nxt   = FCS_LAST;
                        end else begin
                            state_nxt = S_DATA;
                        end
                    end else begin
                        drop_nxt = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (in_xfer) begin
                    crc_nxt = crc_byte(crc, I_data);
                    ld      = 1'b1;
                    ld_data = I_data;
`ifdef CRC_APPEND_PAD_EN
                    pad_nxt = (pad_left == 16'd0) ? 16'd0 : pad_left - 16'd1;
                    go_pad  = (pad_nxt != 16'd0);
`endif
                    if (I_eof) begin
                        state_nxt = go_pad ? S_PAD : S_FCS;
                        fcs_nxt   = FCS_LAST;
                    end
                end
            end
`ifdef CRC_APPEND_PAD_EN
            S_PAD: begin
                if (out_free) begin
                    crc_nxt = crc_byte(crc, 8'h00);
                    ld      = 1'b1;
                    ld_data = 8'h00;
                    pad_nxt = pad_left - 16'd1;
                    if (pad_left == 16'd1) begin
                        state_nxt = S_FCS;
                        fcs_nxt   = FCS_LAST;
                    end
                end
            end
`endif
            S_FCS: begin
                if (out_free) begin
                    ld      = 1'b1;
                    ld_data = bitrev8(fcs_top);
                    ld_eof  = (fcs_left == 3'd0);
                    crc_nxt = crc << 8;
                    if (fcs_left == 3'd0) begin
                        state_nxt = S_IDLE;
                    end else begin
                        fcs_nxt = fcs_left - 3'd1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, CRC register, counters and the single output register.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state    <= S_IDLE;
            crc      <= C_INIT;
            fcs_left <= 3'd0;
            rdy_en   <= 1'b0;
            out_data <= 8'h00;
            out_v    <= 1'b0;
            out_sof  <= 1'b0;
            out_eof  <= 1'b0;
            drop     <= 1'b0;
`ifdef CRC_APPEND_PAD_EN
            pad_left <= 16'd0;
`endif
        end else begin
            state    <= state_nxt;
            crc      <= crc_nxt;
            fcs_left <= fcs_nxt;
            rdy_en   <= 1'b1;
            drop     <= drop_nxt;
`ifdef CRC_APPEND_PAD_EN
            pad_left <= pad_nxt;
`endif
            if (ld) begin
                out_data <= ld_data;
                out_v    <= 1'b1;
                out_sof  <= ld_sof;
                out_eof  <= ld_eof;
            end else if (I_ready) begin
                out_v    <= 1'b0;
                out_sof  <= 1'b0;
                out_eof  <= 1'b0;
            end
        end
    end

    assign O_ready  = ready_int;
    assign O_data   = out_data;
    assign O_data_v = out_v;
    assign O_sof    = out_sof;
    assign O_eof    = out_eof;
    assign O_drop   = drop;

endmodule
